// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared widths, state codes and sign-extension helper for the MFCC pipeline
package mfcc_pkg;

  localparam int MEL_W_D   = 44;
  localparam int ENG_W_D   = 39;
  localparam int OUT_W_D   = 44;
  localparam int NUM_MEL_D = 23;

  // Widest word any stage sign-extends through the shared helper
  localparam int SEXT_W = 64;

  localparam logic [0:0] ST_ENG = 1'b0;
  localparam logic [0:0] ST_MEL = 1'b1;

  typedef logic [SEXT_W-1:0] sext_t;

  // Replicates bit from_w-1 of value into every bit at or above from_w
  function automatic sext_t sext(input sext_t value, input int from_w);
    sext_t mask;
    sext_t sign_pos;
    mask     = {SEXT_W{1'b1}} << from_w;
    sign_pos = value >> (from_w - 1);
    if (sign_pos[0]) begin
      sext = value | mask;
    end else begin
      sext = value & ~mask;
    end
  endfunction

endpackage

// File: rtl/muxlog_outreg.sv
// rtl/muxlog_outreg.sv - single-entry valid/ready output register that holds its word while stalled
module muxlog_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  // A new word may enter when the slot is empty or is being drained this cycle
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/muxlog_stream.sv
// rtl/muxlog_stream.sv - streaming energy/mel frame selector with sign extension ahead of the log stage
module muxlog_stream
  import mfcc_pkg::*;
#(
  parameter int MEL_W   = MEL_W_D,
  parameter int ENG_W   = ENG_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int NUM_MEL = NUM_MEL_D,
  parameter int IDX_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             energy_en,
  input  logic             eng_valid,
  input  logic [ENG_W-1:0] eng_data,
  output logic             eng_ready,
  input  logic             mel_valid,
  input  logic [MEL_W-1:0] mel_data,
  output logic             mel_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_is_eng,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int PW = OUT_W + IDX_W + 2;

  logic [0:0]       phase_q;
  logic             start_q;
  logic             eng_mode_q;
  logic [IDX_W-1:0] mel_cnt_q;

  logic             cur_mode;
  logic [0:0]       cur_state;
  logic             can_load;
  logic             eng_acc;
  logic             mel_acc;
  logic             mel_last;
  logic [IDX_W-1:0] mel_idx;
  logic [OUT_W-1:0] eng_ext;
  logic [OUT_W-1:0] mel_ext;
  logic             load_valid;
  logic [PW-1:0]    load_word;
  logic [PW-1:0]    held_word;

  // Frame start is resolved combinationally from energy_en so it never costs a cycle
  always_comb begin
    cur_mode  = start_q ? energy_en : eng_mode_q;
    cur_state = start_q ? (energy_en ? ST_ENG : ST_MEL) : phase_q;
  end

  assign eng_ready = !rst && can_load && (cur_state == ST_ENG);
  assign mel_ready = !rst && can_load && (cur_state == ST_MEL);
  assign eng_acc   = eng_valid && eng_ready;
  assign mel_acc   = mel_valid && mel_ready;

  assign mel_last = (mel_cnt_q == IDX_W'(NUM_MEL - 1));
  assign mel_idx  = cur_mode ? (mel_cnt_q + IDX_W'(1)) : mel_cnt_q;

  assign eng_ext = OUT_W'(sext(SEXT_W'(eng_data), ENG_W));
  assign mel_ext = OUT_W'(sext(SEXT_W'(mel_data), MEL_W));

  assign load_valid = eng_acc || mel_acc;

  always_comb begin
    load_word = '0;
    if (eng_acc) begin
      load_word = {1'b1, 1'b0, {IDX_W{1'b0}}, eng_ext};
    end else begin
      load_word = {1'b0, mel_last, mel_idx, mel_ext};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= ST_ENG;
      start_q    <= 1'b1;
      eng_mode_q <= 1'b0;
      mel_cnt_q  <= '0;
    end else if (eng_acc) begin
      phase_q    <= ST_MEL;
      start_q    <= 1'b0;
      eng_mode_q <= cur_mode;
    end else if (mel_acc) begin
      phase_q    <= ST_MEL;
      eng_mode_q <= cur_mode;
      if (mel_last) begin
        start_q   <= 1'b1;
        mel_cnt_q <= '0;
      end else begin
        start_q   <= 1'b0;
        mel_cnt_q <= mel_cnt_q + IDX_W'(1);
      end
    end
  end

  muxlog_outreg #(
    .W(PW)
  ) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (load_valid),
    .in_data  (load_word),
    .in_ready (can_load),
    .out_valid(out_valid),
    .out_data (held_word),
    .out_ready(out_ready)
  );

  assign {out_is_eng, out_last, out_idx, out_data} = held_word;

endmodule

// File: doc/muxlog_stream.md
Name: muxlog_stream

Overview:
- Streaming, parametrised successor to the combinational mel/energy selector feeding the log stage of the MFCC feature pipeline.
- Accepts one frame energy word and NUM_MEL mel-filterbank sums per frame over valid/ready handshakes.
- Sign-extends each word to OUT_W and emits the frame in fixed order (energy, then mel 0..NUM_MEL-1) through a registered, back-pressurable output with index and last tags.
- A runtime mode drops the energy slot for mel-only frames.

Parameters:
- MEL_W, 44, mel sum width (two's complement); MEL_W <= OUT_W.
- ENG_W, 39, energy word width (two's complement); ENG_W <= OUT_W.
- OUT_W, 44, output word width to the log stage.
- NUM_MEL, 23, mel channels per frame; must be >= 1.
- IDX_W, 5, index width; 2**IDX_W >= NUM_MEL+1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- energy_en  in  1  1 = frame includes energy slot; sampled at frame start only.
- eng_valid  in  1  energy word valid.
- eng_data  in  ENG_W  energy word.
- eng_ready  out  1  energy word accepted when eng_valid & eng_ready.
- mel_valid  in  1  mel word valid.
- mel_data  in  MEL_W  mel word, channel order 0..NUM_MEL-1.
- mel_ready  out  1  mel word accepted when mel_valid & mel_ready.
- out_valid  out  1  output word valid.
- out_data  out  OUT_W  sign-extended word.
- out_is_eng  out  1  1 = word is the energy slot.
- out_idx  out  IDX_W  slot index: energy = 0; mel k = k+1 if energy_en, else k.
- out_last  out  1  final word of frame (mel NUM_MEL-1).
- out_ready  in  1  downstream accept.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values: out_valid=0, out_data=0, out_is_eng=0, out_idx=0, out_last=0, eng_ready=0, mel_ready=0. State=S_START, mel_cnt=0, eng_mode=0.
- FSM:
  - S_START: combinational, zero-cycle. Latch energy_en into eng_mode. Go to S_ENG if 1, else S_MEL in the same evaluation; it does not consume a cycle.
  - S_ENG: wait for the energy word. Go to S_MEL on accept.
  - S_MEL: accept NUM_MEL mel words. On accept of word NUM_MEL-1, go back to S_START.
- Implementation: a two-state register (ENG/MEL) plus frame-start flag is acceptable.
- Ready rules:
  - can_load = !out_valid | out_ready.
  - eng_ready = can_load & state==S_ENG.
  - mel_ready = can_load & state==S_MEL.
  - Never both high. A mel word offered during S_ENG is held off, not dropped.
- Output register:
  - Loads on accept; latency exactly 1 cycle, accept edge to out_valid.
  - Full throughput of 1 word/cycle when out_ready is held high.
  - While out_valid & !out_ready, out_data, out_is_eng, out_idx and out_last are held stable.
  - out_valid drops the cycle after the handshake if no new accept occurs.
- Width rules:
  - out_data = {{(OUT_W-ENG_W){eng_data[ENG_W-1]}}, eng_data} for energy.
  - out_data = {{(OUT_W-MEL_W){mel_data[MEL_W-1]}}, mel_data} for mel.
  - If MEL_W==OUT_W, mel passes through unchanged.
  - No saturation or rounding.
- Counter: mel_cnt increments per mel accept and wraps to 0 after NUM_MEL-1. out_last = (mel_cnt==NUM_MEL-1) at load.
- energy_en changes mid-frame are ignored until the next frame start.
- Reset mid-frame: all state, counter and output register clear asynchronously; any in-flight output word is lost; the next frame starts fresh.
- NUM_MEL=1: every mel word has out_last=1.

Decomposition:
- Shared package mfcc_pkg:
  - default widths MEL_W_D=44, ENG_W_D=39, OUT_W_D=44, NUM_MEL_D=23;
  - state encoding constants ST_ENG/ST_MEL;
  - a sign-extension function sext(value, from_w) used here and by later log/DCT stages.
- One natural sub-module: muxlog_outreg, the single-entry valid/ready output register with hold-on-stall, reusable by the log stage.

Test Plan (NUM_MEL=4, IDX_W=3 unless stated):
1. Energy sign-extend. energy_en=1, eng_data=39'h40_0000_0000, out_ready=1 -> next cycle out_data=44'hFC0_0000_0000, out_is_eng=1, out_idx=0. Then mel 44'h1,2,3,4 -> out_idx 1..4, out_last only on idx 4.
2. Positive energy, mel-only, back-to-back. energy_en=1: eng_data=39'h1_2345 -> out_data=44'h000_0001_2345. Next frame with energy_en=0: mel words 10,20,30,40 -> out_is_eng=0, out_idx 0..3, one word/cycle, out_last on 40.
3. Stall. Hold out_ready=0 for 5 cycles after the first mel load -> out_data/out_idx stable, eng_ready=mel_ready=0. Release -> resume with no loss or duplication.
4. Ordering. mel_valid=1 presented before eng_valid in an energy frame -> mel_ready=0 until energy is accepted; output order is energy, then mel0.
5. Reset mid-frame. Assert rst asynchronously after 2 mel accepts -> outputs zero immediately without a clock edge. After release, a fresh frame starts at energy with out_idx=0.
6. Mode change mid-frame and NUM_MEL=1. Toggle energy_en mid-frame -> no effect until the next frame. With NUM_MEL=1 -> out_last=1 on every mel word.
